// File: rtl/sha256_sched_pkg.sv
// Shared types and defaults for the SHA-256 job scheduler.
package sha256_sched_pkg;

  // Word-address width of the simplified_sha256 core's address ports.
  localparam int unsigned SHA_ADDR_W = 16;

  // Scheduler job lifecycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ACK,
    S_RUN,
    S_CMPL
  } sched_state_e;

endpackage

// File: rtl/sha256_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  // Scan requesters in priority order ptr, ptr+1, ... wrapping at N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one simplified_sha256 core among NUM_REQ requesters: round-robin
// job accept, start pulse, busy/done tracking with timeouts, completion pulse.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = SHA_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned RUN_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_msg_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_out_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          cmp_valid,
  output logic                        cmp_error,
  output logic                        core_start,
  output logic [ADDR_W-1:0]           core_msg_addr,
  output logic [ADDR_W-1:0]           core_out_addr,
  input  logic                        core_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_LIM = CW'(RUN_TIMEOUT - 1);

  sched_state_e        state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]   msg_q, msg_d;
  logic [ADDR_W-1:0]   out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic [NUM_REQ-1:0]  cmpv_q, cmpv_d;
  logic                cmpe_q, cmpe_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                grant_ok;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // reset_n gates the accept so req_ready reads zero while reset is held.
  assign grant_ok = reset_n && (state_q == S_IDLE) && arb_any && core_done;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and error classification.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          state_d = S_START;
          err_d   = 1'b0;
        end
      end
      S_START: state_d = S_ACK;
      S_ACK: begin
        if (!core_done) begin
          state_d = S_RUN;
        end else if (cnt_q >= ACK_LIM) begin
          state_d = S_CMPL;
          err_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_CMPL;
          err_d   = 1'b0;
        end else if (cnt_q >= RUN_LIM) begin
          state_d = S_CMPL;
          err_d   = 1'b1;
        end
      end
      S_CMPL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: accept strobe now, registered pulses for the next cycle.
  always_comb begin
    req_ready = grant_ok ? arb_gnt : '0;
    start_d   = grant_ok;
    cmpv_d    = '0;
    cmpe_d    = 1'b0;
    if (state_d == S_CMPL) begin
      cmpv_d[grant_q] = 1'b1;
      cmpe_d          = err_d;
    end
  end

  // Job capture, pointer advance and the per-state saturating counter.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    msg_d   = msg_q;
    out_d   = out_q;
    if (grant_ok) begin
      ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      grant_d = arb_idx;
      msg_d   = req_msg_addr[arb_idx*ADDR_W +: ADDR_W];
      out_d   = req_out_addr[arb_idx*ADDR_W +: ADDR_W];
    end
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      msg_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      cmpv_q  <= '0;
      cmpe_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= start_d;
      cmpv_q  <= cmpv_d;
      cmpe_q  <= cmpe_d;
    end
  end

  assign core_start    = start_q;
  assign cmp_valid     = cmpv_q;
  assign cmp_error     = cmpe_q;
  assign core_msg_addr = msg_q;
  assign core_out_addr = out_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Randomized self-checking bench for sha256_job_scheduler with a
// job-level reference model and a scripted core model.
module tb_sha256_job_scheduler;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int ACK = 8;
  localparam int RUN = 300;
  localparam int IW  = $clog2(N);
  localparam longint INF = 64'd1 << 40;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_msg_addr;
  logic [N*AW-1:0]   req_out_addr;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      cmp_valid;
  logic              cmp_error;
  logic              core_start;
  logic [AW-1:0]     core_msg_addr;
  logic [AW-1:0]     core_out_addr;
  logic              core_done;
  logic              busy;
  logic [IW-1:0]     grant_id;

  sha256_job_scheduler #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .ACK_TIMEOUT (ACK),
    .RUN_TIMEOUT (RUN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_msg_addr  (req_msg_addr),
    .req_out_addr  (req_out_addr),
    .req_ready     (req_ready),
    .cmp_valid     (cmp_valid),
    .cmp_error     (cmp_error),
    .core_start    (core_start),
    .core_msg_addr (core_msg_addr),
    .core_out_addr (core_out_addr),
    .core_done     (core_done),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  longint      cyc   = 0;
  int          model_ptr = 0;
  logic [AW-1:0] msg_a [N];
  logic [AW-1:0] out_a [N];

  // Core model: done is low for cycles [fall, rise), or whenever hold_low.
  longint fall = INF;
  longint rise = INF;
  logic   hold_low = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Start of a cycle: inputs for this cycle are applied here.
  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    core_done = !(hold_low || (cyc >= fall && cyc < rise));
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) begin
      msg_a[i] = AW'($urandom);
      out_a[i] = AW'($urandom);
    end
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < N; i++) begin
      req_msg_addr[i*AW +: AW] = msg_a[i];
      req_out_addr[i*AW +: AW] = out_a[i];
    end
  endtask

  task automatic do_reset();
    adv();
    reset_n   = 1'b0;
    fall      = INF;
    rise      = INF;
    hold_low  = 1'b0;
    core_done = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_cmpv",  64'(cmp_valid), 64'(0));
    chk("rst_cmpe",  64'(cmp_error), 64'(0));
    chk("rst_start", 64'(core_start), 64'(0));
    chk("rst_msg",   64'(core_msg_addr), 64'(0));
    chk("rst_out",   64'(core_out_addr), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_gid",   64'(grant_id), 64'(0));
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      adv();
      smp();
      chk("rst_hold", 64'({cmp_valid, core_start, busy}), 64'(0));
    end
    adv();
    reset_n = 1'b1;
    smp();
    chk("rst_rel_busy", 64'(busy), 64'(0));
    model_ptr = 0;
  endtask

  // One job: optional core-busy idle cycles, accept, start, core behaviour,
  // completion. d0 = cycles after ACK entry before done falls (out of range
  // means never); low = cycles done stays low (out of range means hung).
  task automatic do_job(input logic [N-1:0] mask, input int d0, input int low,
                        input int pre, input logic [N-1:0] extra, input int abort_after);
    int          g;
    logic [N-1:0] oh;
    longint      s, ec;
    logic        err;
    g     = rr_pick(mask, model_ptr);
    oh    = '0;
    oh[g] = 1'b1;
    drive_addrs();
    for (int p = 0; p < pre; p++) begin
      hold_low = 1'b1;
      adv();
      req_valid = mask | extra;
      smp();
      chk("core_busy_no_ready", 64'(req_ready), 64'(0));
      chk("core_busy_idle", 64'(busy), 64'(0));
    end
    hold_low = 1'b0;
    adv();
    req_valid = mask;
    smp();
    chk("ready", 64'(req_ready), 64'(oh));
    chk("idle_before_grant", 64'(busy), 64'(0));
    adv();
    req_valid[g] = 1'b0;
    smp();
    s = cyc;
    chk("start", 64'(core_start), 64'(1));
    chk("msg_addr", 64'(core_msg_addr), 64'(msg_a[g]));
    chk("out_addr", 64'(core_out_addr), 64'(out_a[g]));
    chk("grant_id", 64'(grant_id), 64'(g));
    chk("no_b2b_grant", 64'(req_ready), 64'(0));
    if (d0 < 0 || d0 >= ACK) begin
      fall = INF;
      rise = INF;
      ec   = s + 1 + ACK;
      err  = 1'b1;
    end else begin
      fall = s + 1 + d0;
      if (low >= 1 && low <= RUN) begin
        ec   = s + 2 + d0 + low;
        err  = 1'b0;
        rise = fall + low;
      end else begin
        ec   = s + 2 + d0 + RUN;
        err  = 1'b1;
        rise = ec;
      end
    end
    if (abort_after >= 0) begin
      for (int k = 0; k < abort_after; k++) begin
        adv();
        smp();
        chk("quiet", 64'({cmp_valid, core_start, req_ready}), 64'(0));
      end
      return;
    end
    for (longint c = s + 1; c < ec; c++) begin
      adv();
      smp();
      chk("quiet", 64'({cmp_valid, core_start, req_ready}), 64'(0));
    end
    adv();
    req_valid = mask;
    smp();
    chk("cmp_valid", 64'(cmp_valid), 64'(oh));
    chk("cmp_error", 64'(cmp_error), 64'(err));
    chk("cmp_busy", 64'(busy), 64'(1));
    model_ptr = (g + 1) % N;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_msg_addr = '0;
    req_out_addr = '0;
    core_done    = 1'b1;
    rand_addrs();

    do_reset();

    // Single job from requester 2 with fixed addresses.
    msg_a[2] = 16'h0000;
    out_a[2] = 16'h0100;
    do_job(4'b0100, 0, 150, 0, 4'b0000, -1);

    // Fairness from a fresh pointer.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      rand_addrs();
      do_job(4'b1111, $urandom_range(0, ACK - 1), $urandom_range(1, 20), 0, 4'b0000, -1);
    end

    // Ack timeout, then the next requester is served normally.
    do_job(4'($urandom_range(1, 15)), -1, 5, 0, 4'b0000, -1);
    do_job(4'b1111, 2, 5, 0, 4'b0000, -1);

    // Timeout boundaries.
    do_job(4'($urandom_range(1, 15)), ACK - 1, 3, 0, 4'b0000, -1);
    do_job(4'($urandom_range(1, 15)), 0, RUN, 0, 4'b0000, -1);
    do_job(4'($urandom_range(1, 15)), 0, RUN + 1, 0, 4'b0000, -1);

    // Run timeout with a hung core.
    do_job(4'($urandom_range(1, 15)), 1, -1, 0, 4'b0000, -1);

    // Reset during S_RUN, then requesters 1 and 3 compete.
    do_job(4'b1111, 0, -1, 0, 4'b0000, 10);
    do_reset();
    do_job(4'b1010, 1, 4, 0, 4'b0000, -1);

    // Core busy while idle, with transient requests dropped before accept.
    do_job(4'b0001, 1, 3, 5, 4'b0110, -1);

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      int lo;
      rand_addrs();
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(RUN - 1, RUN + 2) : $urandom_range(1, 25);
      do_job(4'($urandom_range(1, 15)), $urandom_range(0, ACK + 1), lo,
             $urandom_range(0, 2), 4'($urandom), -1);
    end

    adv();
    req_valid = '0;
    smp();
    chk("final_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
